// File: rtl/dmabuf_ptr_mgmt_mc.sv
// Multi-channel DMA host-buffer write-pointer manager.
// Each channel keeps a ring write pointer and derives used/free page counts from the host read pointer.
module dmabuf_ptr_mgmt_mc #(
    parameter int NCH      = 4,
    parameter int PW       = 32,
    parameter int RSV      = 1,
    parameter int OUT_FLOP = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [NCH-1:0]    iRST_PTR,
    input  logic [NCH-1:0]    iINC_WR_PTR,
    input  logic [NCH*PW-1:0] iSTART_PFN,
    input  logic [NCH*PW-1:0] iLAST_PFN,
    input  logic [NCH*PW-1:0] iRD_PTR,
    input  logic [NCH-1:0]    iCLR_OVFL,
    output logic [NCH*PW-1:0] oWR_PTR,
    output logic [NCH*PW-1:0] oFREE,
    output logic [NCH-1:0]    oFULL,
    output logic [NCH-1:0]    oEMPTY,
    output logic [NCH-1:0]    oOVFL
);

    localparam logic [PW-1:0]        ONE_U = PW'(1);
    localparam logic signed [PW+1:0] ONE_S = (PW+2)'(1);
    localparam logic signed [PW+1:0] RSV_S = (PW+2)'(RSV);

    // Modulo-N distance from the read pointer to the write pointer.
    function automatic logic [PW:0] ring_used(input logic [PW-1:0] wr,
                                              input logic [PW-1:0] rd,
                                              input logic [PW-1:0] n);
        if (wr >= rd)
            ring_used = {1'b0, wr} - {1'b0, rd};
        else
            ring_used = {1'b0, n} - {1'b0, rd} + {1'b0, wr};
    endfunction

    // Free pages = N - 1 - used - RSV, clamped at zero (also covers N == 0 and bogus RD_PTR).
    function automatic logic [PW-1:0] sat_free(input logic [PW-1:0] n,
                                               input logic [PW:0]   used);
        logic signed [PW+1:0] room;
        room = $signed({2'b00, n}) - $signed({1'b0, used}) - ONE_S;
        if (room < RSV_S)
            sat_free = '0;
        else
            sat_free = PW'(room - RSV_S);
    endfunction

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [PW-1:0] s_q, l_q, r_q, r_p1, n_q, wr_q;
        logic [PW:0]   used_d, used_p2;
        logic          full_p2, ovfl_q;
        logic [PW-1:0] free_c;
        logic          empty_c;

        assign used_d  = ring_used(wr_q, r_p1, n_q);
        assign free_c  = sat_free(n_q, used_p2);
        assign empty_c = (used_p2 == '0);

        // stage 0/1: input capture, ring size and read pointer aligned to it
        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) begin
                s_q  <= '0;
                l_q  <= '0;
                r_q  <= '0;
                r_p1 <= '0;
                n_q  <= '0;
            end else begin
                s_q  <= iSTART_PFN[c*PW +: PW];
                l_q  <= iLAST_PFN[c*PW +: PW];
                r_q  <= iRD_PTR[c*PW +: PW];
                r_p1 <= r_q;
                n_q  <= l_q - s_q + ONE_U;
            end
        end

        // write pointer and sticky overflow
        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) begin
                wr_q   <= '0;
                ovfl_q <= 1'b0;
            end else begin
                if (iRST_PTR[c])
                    wr_q <= s_q;
                else if (iINC_WR_PTR[c] && !full_p2) begin
                    if (wr_q == l_q)
                        wr_q <= s_q;
                    else
                        wr_q <= wr_q + ONE_U;
                end

                if (iINC_WR_PTR[c] && full_p2 && !iRST_PTR[c])
                    ovfl_q <= 1'b1;
                else if (iCLR_OVFL[c] || iRST_PTR[c])
                    ovfl_q <= 1'b0;
            end
        end

        // stage 2: occupancy; full is computed from the same used value that drives oFREE
        always_ff @(posedge iCLK or posedge iRST) begin
            if (iRST) begin
                used_p2 <= '0;
                full_p2 <= 1'b1;
            end else begin
                used_p2 <= used_d;
                full_p2 <= (sat_free(n_q, used_d) == '0);
            end
        end

        assign oWR_PTR[c*PW +: PW] = wr_q;
        assign oOVFL[c]            = ovfl_q;

        if (OUT_FLOP != 0) begin : g_oflop
            logic [PW-1:0] free_p3;
            logic          full_p3, empty_p3;

            // stage 3: optional output retiming
            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    free_p3  <= '0;
                    full_p3  <= 1'b1;
                    empty_p3 <= 1'b1;
                end else begin
                    free_p3  <= free_c;
                    full_p3  <= full_p2;
                    empty_p3 <= empty_c;
                end
            end

            assign oFREE[c*PW +: PW] = free_p3;
            assign oFULL[c]          = full_p3;
            assign oEMPTY[c]         = empty_p3;
        end else begin : g_direct
            assign oFREE[c*PW +: PW] = free_c;
            assign oFULL[c]          = full_p2;
            assign oEMPTY[c]         = empty_c;
        end
    end

endmodule
